// File: rtl/barrel_unshifter_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : barrel_unshifter_seq_pkg
//  Description : Definitions shared by the barrel shifter family. Holds the
//                FSM state encodings and the default operand width.
//                barrel_shifter and barrel_unshifter_seq both import this
//                package, so a change here affects both blocks.
//  Revision    : 1.0  initial release
// ============================================================================
package barrel_unshifter_seq_pkg;

    // Default operand width for the barrel datapath.
    localparam int BARREL_WIDTH = 4;

    // FSM state encodings. They are 2 bits wide, so 2'd3 is unreachable.
    // The FSM sends that code back to idle.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage : barrel_unshifter_seq_pkg
`default_nettype wire

// File: rtl/barrel_unshifter_seq_rotr_step.sv
`default_nettype none
// ============================================================================
//  Module      : rotr_step
//  Description : Combinational rotate right by one position.
//                o_dout[i] = i_din[(i+1) % WIDTH], so bit 0 wraps round to
//                bit WIDTH-1.
//  Ports       : i_din   [WIDTH-1:0]  operand
//                o_dout  [WIDTH-1:0]  operand rotated right by one
//  Revision    : 1.0  initial release
// ============================================================================
module rotr_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            assign o_dout[i] = i_din[(i + 1) % WIDTH];
        end
    endgenerate

endmodule : rotr_step
`default_nettype wire

// File: rtl/barrel_unshifter_seq.sv
`default_nettype none
// ============================================================================
//  Module      : barrel_unshifter_seq
//  Description : Sequential rotate right. It undoes the left rotate applied
//                by barrel_shifter, rotating one position per clock.
//                Input and output both use valid/ready handshakes.
//                Latency from the accepting edge to out_valid is sel+1 edges.
//  Ports       : clk        system clock, rising edge
//                rst_n      asynchronous active-low reset
//                in_valid   a/sel valid
//                in_ready   operand can be accepted (IDLE only)
//                a          [WIDTH-1:0] operand
//                sel        [SW-1:0]    right-rotate amount
//                out_valid  shift_out holds a final result (DONE)
//                out_ready  consumer accepts the result
//                shift_out  [WIDTH-1:0] registered rotated result
//                busy       high in SHIFT and DONE
//  Revision    : 1.0  initial release
// ============================================================================
module barrel_unshifter_seq
    import barrel_unshifter_seq_pkg::*;
#(
    parameter  int WIDTH = BARREL_WIDTH,   // power of two, >= 2
    localparam int SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [SW-1:0]    sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] shift_out,
    output logic             busy
);

    logic [1:0]       r_state;
    logic [SW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_rot;

    // The one-position rotator sits in the SHIFT datapath.
    rotr_step #(
        .WIDTH (WIDTH)
    ) u_rotr_step (
        .i_din  (r_shift),
        .o_dout (w_rot)
    );

    // The handshake outputs are decoded directly from the state register.
    // This keeps them glitch-free and holds them stable while in DONE.
    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = !in_ready;
    assign shift_out = r_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_shift <= a;
                        r_cnt   <= sel;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // The zero test comes before the decrement, so the
                    // counter never wraps below zero.
                    if (r_cnt == '0) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_shift <= w_rot;
                        r_cnt   <= r_cnt - SW'(1);
                    end
                end
                ST_DONE: begin
                    // There is no same-cycle turnaround. The next operand
                    // is only taken after a full cycle back in IDLE.
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : barrel_unshifter_seq
`default_nettype wire

// File: tb/tb_barrel_unshifter_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_barrel_unshifter_seq
//  Description : Self-checking bench for barrel_unshifter_seq. It pushes the
//                expected result and latency onto a scoreboard queue when an
//                operand is driven. The entry is popped and compared when the
//                DUT raises out_valid.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_barrel_unshifter_seq;

    localparam int WIDTH   = 4;
    localparam int SW      = 2;
    localparam int TIMEOUT = 20;

    typedef struct {
        logic [WIDTH-1:0] res;
        int               lat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [SW-1:0]    sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] shift_out;
    logic             busy;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    barrel_unshifter_seq #(
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .shift_out (shift_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Independent reference models: a plain loop of single-bit rotations.
    function automatic logic [WIDTH-1:0] rotr_model(logic [WIDTH-1:0] v, int s);
        logic [WIDTH-1:0] t;
        t = v;
        for (int i = 0; i < s; i++) t = {t[0], t[WIDTH-1:1]};
        return t;
    endfunction

    function automatic logic [WIDTH-1:0] rotl_model(logic [WIDTH-1:0] v, int s);
        logic [WIDTH-1:0] t;
        t = v;
        for (int i = 0; i < s; i++) t = {t[WIDTH-2:0], t[WIDTH-1]};
        return t;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".in_ready"},  32'(in_ready),  32'd1);
        check({tag, ".busy"},      32'(busy),      32'd0);
    endtask

    // Wait, with a bound, for out_valid. Count the falling edges seen since
    // the accepting rising edge. The count equals the number of rising edges
    // that have occurred.
    task automatic wait_result(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < TIMEOUT) begin
            @(negedge clk);
            cycles++;
        end
        if (!out_valid) begin
            check("timeout.out_valid", 32'(out_valid), 32'd1);
        end
    endtask

    task automatic pop_compare(input string tag, input int cycles, input bit chk_lat);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, ".scoreboard_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check({tag, ".shift_out"}, 32'(shift_out), 32'(e.res));
        if (chk_lat) check({tag, ".latency"}, 32'(cycles), 32'(e.lat));
    endtask

    // Run one full transaction with out_ready held high. The expected result
    // is supplied by the caller.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] av,
                          input logic [SW-1:0] sv, input logic [WIDTH-1:0] expv);
        int   cyc;
        exp_t e;
        @(negedge clk);
        check({tag, ".in_ready_pre"}, 32'(in_ready), 32'd1);
        a         = av;
        sel       = sv;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        e.res     = expv;
        e.lat     = int'(sv) + 1;
        sb.push_back(e);
        @(negedge clk);
        in_valid  = 1'b0;
        wait_result(cyc);
        pop_compare(tag, cyc, 1'b1);
        @(negedge clk);
        check({tag, ".in_ready_post"}, 32'(in_ready), 32'd1);
    endtask

    logic [WIDTH-1:0] exp_1101 [4];
    logic [WIDTH-1:0] exp_0110 [4];

    initial begin
        int   cyc;
        exp_t e;

        exp_1101[0] = 4'b1101; exp_1101[1] = 4'b1110;
        exp_1101[2] = 4'b0111; exp_1101[3] = 4'b1011;
        exp_0110[0] = 4'b0110; exp_0110[1] = 4'b0011;
        exp_0110[2] = 4'b1001; exp_0110[3] = 4'b1100;

        // ---------------- reset ----------------
        rst_n = 1'b0; in_valid = 1'b0; a = '0; sel = '0; out_ready = 1'b0;
        #100;
        check("rst.shift_out", 32'(shift_out), 32'd0);
        check_idle_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_rel.shift_out", 32'(shift_out), 32'd0);
        check_idle_outputs("rst_rel");

        // ---------------- directed results and latency ----------------
        for (int s = 0; s < 4; s++) run_op($sformatf("a1101_s%0d", s), 4'b1101, SW'(s), exp_1101[s]);
        for (int s = 0; s < 4; s++) run_op($sformatf("a0110_s%0d", s), 4'b0110, SW'(s), exp_0110[s]);

        // ---------------- round trip of all 16x4 cases ----------------
        for (int v = 0; v < 16; v++)
            for (int s = 0; s < 4; s++)
                run_op($sformatf("rt_a%0h_s%0d", v, s), rotl_model(4'(v), s), SW'(s), 4'(v));

        // ---------------- backpressure ----------------
        @(negedge clk);
        a = 4'b1101; sel = 2'd2; in_valid = 1'b1; out_ready = 1'b0;
        e.res = rotr_model(4'b1101, 2); e.lat = 3;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        wait_result(cyc);
        pop_compare("bp", cyc, 1'b1);
        for (int i = 0; i < 5; i++) begin
            // Pulse a second operand mid-stall. The DUT must ignore it.
            if (i == 2) begin a = 4'b0000; sel = 2'd1; in_valid = 1'b1; end
            else        in_valid = 1'b0;
            @(negedge clk);
            check($sformatf("bp%0d.out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d.shift_out", i), 32'(shift_out), 32'b0111);
            check($sformatf("bp%0d.in_ready", i),  32'(in_ready),  32'd0);
            check($sformatf("bp%0d.busy", i),      32'(busy),      32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check_idle_outputs("bp_accept");
        check("bp_accept.shift_out_held", 32'(shift_out), 32'b0111);

        // ---------------- reset in the middle of SHIFT ----------------
        @(negedge clk);
        a = 4'b1101; sel = 2'd3; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("midrst.busy_before", 32'(busy), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst.shift_out", 32'(shift_out), 32'd0);
        check_idle_outputs("midrst");
        @(negedge clk);
        check_idle_outputs("midrst_hold");
        rst_n = 1'b1;
        run_op("after_rst", 4'b0110, 2'd1, 4'b0011);

        // ---------------- back-to-back ----------------
        @(negedge clk);
        a = 4'b1011; sel = 2'd1; in_valid = 1'b1; out_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            e.res = rotr_model(4'b1011, 1); e.lat = 2;
            sb.push_back(e);
            @(negedge clk);
            check($sformatf("b2b%0d.captured", n), 32'(in_ready), 32'd0);
            wait_result(cyc);
            pop_compare($sformatf("b2b%0d", n), cyc, 1'b1);
            @(negedge clk);
            check($sformatf("b2b%0d.idle_gap", n),  32'(in_ready),  32'd1);
            check($sformatf("b2b%0d.valid_low", n), 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        // The fourth operand was captured on the last idle cycle.
        check("b2b_end.busy", 32'(busy), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_barrel_unshifter_seq
`default_nettype wire
